mtr_drv_slew: RTL and testbench
===============================

# mtr_drv_slew

Parametrised multi-channel successor to the two-channel motor driver. It converts NCH signed duty commands into sign/magnitude drive: one direction bit plus one PWM output per channel. New behaviour over the fixed design:
- configurable width and channel count;
- magnitude clamping;
- per-period slew-rate limiting;
- a forced zero period on reversal;
- dead-time blanking after a direction change;
- a global enable.

It sits between the steering/PID output and the H-bridge pins.

## Interface
- NCH, 2: number of motor channels
- DUTY_W, 12: signed duty width; PWM resolution is DUTY_W-1 bits
- STEP, 64: max change of applied duty per PWM period (1..2^(DUTY_W-1)-1)
- DEAD, 8: PWM blanking cycles after a direction change (0..2^(DUTY_W-1)-1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  drive enable
- duty  in  NCH*DUTY_W  signed two's-complement command per channel; channel i at [i*DUTY_W +: DUTY_W]
- dir  out  NCH  1 = reverse (applied duty negative)
- pwm  out  NCH  PWM drive
- period_start  out  1  high in every cycle where cnt==0
- ramping  out  NCH  1 = applied duty differs from clamped target

## Operation

**Shared counter**
- cnt is DUTY_W-1 bits, free-running 0..MAX, with MAX = 2^(DUTY_W-1)-1.
- Wraps to 0; period = 2^(DUTY_W-1) cycles (2048 by default).

**Clamp**
- target = duty clamped to [-MAX, +MAX].
- Only the most negative code changes: 0x800 becomes -2047.

**Slew update** (per channel)
- Happens only on the edge where cnt==MAX, so the new value is valid in the cnt==0 cycle.
- diff = target - app, computed in DUTY_W+1 bits.
- If |diff| <= STEP: app_next = target; otherwise app_next = app ± STEP.
- Zero crossing: if app and app_next are both nonzero with opposite signs, app_next = 0.

**dir**
- Updated with app: 1 if app_next < 0, 0 if app_next > 0, held if app_next == 0.

**Blanking**
- When dir changes at a period start, pwm is forced low for cnt 0..DEAD-1 of that period.

**pwm**
- pwm = en & ~blank & (cnt < |app|), registered.
- |app| = MAX gives high for MAX of 2^(DUTY_W-1) cycles; app = 0 gives constant low.

**ramping**
- ramping = (app != target), where target is the value sampled at the last update.

**en low**
- pwm = 0 from the next edge.
- app is cleared to 0 every cycle; dir and cnt are held/running.
- After en rises, ramping restarts from 0 at the next wrap.

## Timing
- Reset values: cnt=0, app=0, dir=0, pwm=0, ramping=0. period_start=1 in the first cycle after reset.
- rst mid-operation restores all reset values on that edge. No partial update is applied; rst wins over a coincident wrap.
- duty is sampled only on the wrap edge. Changes at any other time are ignored until the next wrap.
- pwm lags cnt by one cycle. High-time per period is exact: |app| cycles minus blanked cycles, but at least 0.
- Latency from a duty change to a full-step pwm change: at most one period plus one cycle. Reaching the target takes ceil(|diff|/STEP) periods, plus one extra period if the zero-crossing rule applies.
- en and wrap on the same edge: en=0 wins, so app=0.

## Structure
- Package mtr_drv_pkg holds the default parameter constants and a clamp function, sat_duty(duty).
- Sub-module mtr_chan is generated NCH times. It contains the clamp, slew, dir, blank timer, comparator and ramping logic for one channel.
- The top level owns cnt, period_start and the enable fan-out.

## Test plan
All scenarios use default parameters; "count" means high cycles per period.
- **Reset:** hold rst 3 cycles with duty=0x100 → pwm=0, dir=0, ramping=0; period_start high in the first post-reset cycle; repeats every 2048 cycles.
- **Ramp up:** ch0 duty 0x000 → 0x100 → counts 64, 128, 192, 256 over 4 periods; ramping falls at the 4th wrap; dir=0.
- **Negative saturation from 0:** duty=0x800 → dir=1 in the first period; count 56 (64 minus 8 blanked); reaches 2047 after 32 periods.
- **Reversal:** app=+32, duty=-100 → next period app=0 (count 0, dir=0); then app=-64, dir=1, count 56; then app=-100, count 100.
- **Enable / reset mid-ramp:** deassert en at cnt=500 → pwm low from the next cycle, app=0. Reassert en → counts restart at 64. Pulse rst mid-ramp → all outputs return to reset values.
- **Independent channels:** ch0=0xF33 (-205), ch1=0x07C (124) → ch0 dir=1, ch1 dir=0. Final counts 205 and 124, reached after 4 and 2 periods respectively.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared constants and helpers for the slew-limited multi-channel motor driver.
// Imported by the top level and by every channel instance.
package mtr_drv_pkg;

    localparam int NCH_D    = 2;
    localparam int DUTY_W_D = 12;
    localparam int STEP_D   = 64;
    localparam int DEAD_D   = 8;

    // Symmetric clamp; only the most negative code actually moves.
    function automatic int sat_duty(input int duty, input int max_mag);
        if (duty < -max_mag) return -max_mag;
        if (duty > max_mag) return max_mag;
        return duty;
    endfunction

endpackage

// File: rtl/mtr_drv_slew_chan.sv
// One motor channel: clamp, slew limiter, direction, blanking and PWM compare.
// Applied duty moves only on the period wrap edge.
module mtr_chan
    import mtr_drv_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_D,
    parameter int STEP   = STEP_D,
    parameter int DEAD   = DEAD_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wrap,
    input  logic [DUTY_W-2:0]        cnt,
    input  logic signed [DUTY_W-1:0] duty,
    output logic                     dir,
    output logic                     pwm,
    output logic                     ramping
);

    localparam int MAX = 2**(DUTY_W-1) - 1;
    localparam logic [DUTY_W-2:0] DEAD_C = (DUTY_W-1)'(DEAD);
    localparam logic signed [DUTY_W:0] STEP_W = (DUTY_W+1)'(STEP);
    localparam logic signed [DUTY_W-1:0] STEP_N = DUTY_W'(STEP);

    logic signed [DUTY_W-1:0] tgt_d;
    logic signed [DUTY_W-1:0] tgt_q;
    logic signed [DUTY_W-1:0] app_q;
    logic signed [DUTY_W-1:0] app_nx;
    logic signed [DUTY_W:0]   diff;
    logic [DUTY_W-2:0]        mag;
    logic                     dir_q;
    logic                     dir_nx;
    logic                     blank_q;
    logic                     blank;
    logic                     pwm_q;

    always_comb begin
        tgt_d = DUTY_W'(sat_duty(int'(duty), MAX));
        diff  = (DUTY_W+1)'(tgt_d) - (DUTY_W+1)'(app_q);
        unique case (1'b1)
            (diff > STEP_W):  app_nx = app_q + STEP_N;
            (diff < -STEP_W): app_nx = app_q - STEP_N;
            default:          app_nx = tgt_d;
        endcase
        // A reversal always passes through one zero period.
        if (app_q != '0 && app_nx != '0 && app_q[DUTY_W-1] != app_nx[DUTY_W-1])
            app_nx = '0;
        dir_nx = dir_q;
        if (app_nx[DUTY_W-1])
            dir_nx = 1'b1;
        else if (app_nx != '0)
            dir_nx = 1'b0;
        mag   = app_q[DUTY_W-1] ? (DUTY_W-1)'(-app_q) : (DUTY_W-1)'(app_q);
        blank = blank_q && (cnt < DEAD_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            app_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b0;
            blank_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_q <= en && !blank && (cnt < mag);
            if (!en) begin
                app_q <= '0;
                if (wrap) begin
                    tgt_q   <= tgt_d;
                    blank_q <= 1'b0;
                end
            end else if (wrap) begin
                app_q   <= app_nx;
                tgt_q   <= tgt_d;
                dir_q   <= dir_nx;
                blank_q <= (dir_nx != dir_q);
            end
        end
    end

    assign dir     = dir_q;
    assign pwm     = pwm_q;
    assign ramping = (app_q != tgt_q);

endmodule

// File: rtl/mtr_drv_slew.sv
// Multi-channel sign/magnitude motor driver with shared PWM counter.
// Owns the period counter and fans enable out to each channel.
module mtr_drv_slew
    import mtr_drv_pkg::*;
#(
    parameter int NCH    = NCH_D,
    parameter int DUTY_W = DUTY_W_D,
    parameter int STEP   = STEP_D,
    parameter int DEAD   = DEAD_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NCH*DUTY_W-1:0] duty,
    output logic [NCH-1:0]        dir,
    output logic [NCH-1:0]        pwm,
    output logic                  period_start,
    output logic [NCH-1:0]        ramping
);

    logic [DUTY_W-2:0] cnt_q;
    logic              wrap;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign wrap         = &cnt_q;
    assign period_start = (cnt_q == '0);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mtr_chan #(
            .DUTY_W (DUTY_W),
            .STEP   (STEP),
            .DEAD   (DEAD)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wrap    (wrap),
            .cnt     (cnt_q),
            .duty    (duty[i*DUTY_W +: DUTY_W]),
            .dir     (dir[i]),
            .pwm     (pwm[i]),
            .ramping (ramping[i])
        );
    end

endmodule

// File: tb/tb_mtr_drv_slew.sv
// Bench for mtr_drv_slew: per-period high counts, dir and ramping
// checked against expectations queued as each duty vector is driven.
module tb_mtr_drv_slew;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] duty;
    logic [1:0]  dir;
    logic [1:0]  pwm;
    logic        period_start;
    logic [1:0]  ramping;

    mtr_drv_slew dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty         (duty),
        .dir          (dir),
        .pwm          (pwm),
        .period_start (period_start),
        .ramping      (ramping)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d0;
        logic [11:0] d1;
        int          c0;
        int          c1;
        logic [1:0]  dr;
        logic [1:0]  rp;
    } vec_t;

    vec_t tbl [15];
    vec_t exp_q [$];
    int   applied = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input int act, input int req);
        applied++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic measure(output int n, output int c0, output int c1,
                           output logic [1:0] d, output logic [1:0] r);
        n  = 0;
        c0 = 0;
        c1 = 0;
        @(negedge clk);
        while (!period_start && n < 4096) begin
            @(negedge clk);
            n++;
        end
        d  = dir;
        r  = ramping;
        c0 += int'(pwm[0]);
        c1 += int'(pwm[1]);
        for (int i = 1; i < 2048; i++) begin
            @(negedge clk);
            c0 += int'(pwm[0]);
            c1 += int'(pwm[1]);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        vec_t       e;
        int         n, c0, c1;
        logic [1:0] d, r;
        duty = {v.d1, v.d0};
        exp_q.push_back(v);
        measure(n, c0, c1, d, r);
        e = exp_q.pop_front();
        chk({nm, ".align"}, n, 0);
        chk({nm, ".cnt0"}, c0, e.c0);
        chk({nm, ".cnt1"}, c1, e.c1);
        chk({nm, ".dir"}, int'(d), int'(e.dr));
        chk({nm, ".ramp"}, int'(r), int'(e.rp));
    endtask

    initial begin
        int   hi;
        int   bad;
        vec_t v;

        tbl[0]  = '{12'hF33, 12'h07C,  56,  64, 2'b01, 2'b11};
        tbl[1]  = '{12'hF33, 12'h07C, 128, 124, 2'b01, 2'b01};
        tbl[2]  = '{12'hF33, 12'h07C, 192, 124, 2'b01, 2'b01};
        tbl[3]  = '{12'hF33, 12'h07C, 205, 124, 2'b01, 2'b00};
        tbl[4]  = '{12'h100, 12'h800,  64,  56, 2'b10, 2'b11};
        tbl[5]  = '{12'h100, 12'h800, 128, 128, 2'b10, 2'b11};
        tbl[6]  = '{12'h100, 12'h800, 192, 192, 2'b10, 2'b11};
        tbl[7]  = '{12'h100, 12'h800, 256, 256, 2'b10, 2'b10};
        tbl[8]  = '{12'h020, 12'h800, 192, 320, 2'b10, 2'b11};
        tbl[9]  = '{12'h020, 12'h800, 128, 384, 2'b10, 2'b11};
        tbl[10] = '{12'h020, 12'h800,  64, 448, 2'b10, 2'b11};
        tbl[11] = '{12'h020, 12'h800,  32, 512, 2'b10, 2'b10};
        tbl[12] = '{12'hF9C, 12'h800,   0, 576, 2'b10, 2'b11};
        tbl[13] = '{12'hF9C, 12'h800,  56, 640, 2'b11, 2'b11};
        tbl[14] = '{12'hF9C, 12'h800, 100, 704, 2'b11, 2'b10};

        // reset held with a live duty command
        rst  = 1'b1;
        en   = 1'b1;
        duty = {12'h100, 12'h100};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.pwm", int'(pwm), 0);
        chk("rst.dir", int'(dir), 0);
        chk("rst.ramp", int'(ramping), 0);
        chk("rst.pstart", int'(period_start), 1);
        rst = 1'b0;
        hi  = 0;
        bad = 0;
        for (int i = 1; i < 2048; i++) begin
            @(negedge clk);
            hi  += int'(pwm[0]) + int'(pwm[1]);
            bad += int'(period_start);
        end
        chk("p0.pwm_high", hi, 0);
        chk("p0.pstart", bad, 0);

        for (int r = 0; r < 4; r++)
            run_vec(tbl[r], $sformatf("indep%0d", r));

        // reset pulse part-way through a ramp
        duty = {12'h800, 12'h100};
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.pwm", int'(pwm), 0);
        chk("mrst.dir", int'(dir), 0);
        chk("mrst.ramp", int'(ramping), 0);
        chk("mrst.pstart", int'(period_start), 1);
        rst = 1'b0;
        hi  = 0;
        for (int i = 1; i < 2048; i++) begin
            @(negedge clk);
            hi += int'(pwm[0]) + int'(pwm[1]);
        end
        chk("mrst.pwm_high", hi, 0);

        for (int r = 4; r < 15; r++)
            run_vec(tbl[r], $sformatf("ramp%0d", r));

        // ch1 keeps slewing toward negative full scale
        for (int k = 12; k <= 32; k++) begin
            v = '{12'hF9C, 12'h800, 100,
                  (k * 64 > 2047) ? 2047 : k * 64,
                  2'b11, {(k < 32), 1'b0}};
            run_vec(v, $sformatf("sat%0d", k));
        end

        // enable dropped mid-period, held low across a wrap
        @(negedge clk);
        chk("en.align", int'(period_start), 1);
        hi = 0;
        for (int i = 1; i < 2048; i++) begin
            @(negedge clk);
            if (i == 500) begin
                chk("en.pre_pwm", int'(pwm), 2);
                en = 1'b0;
            end
            if (i == 501) begin
                chk("en.off_pwm", int'(pwm), 0);
                chk("en.off_ramp", int'(ramping), 3);
                chk("en.off_dir", int'(dir), 3);
            end
            if (i > 501)
                hi += int'(pwm[0]) + int'(pwm[1]);
        end
        chk("en.off_high", hi, 0);
        run_vec('{12'hF9C, 12'h800, 0, 0, 2'b11, 2'b11}, "en_low");
        en = 1'b1;
        run_vec('{12'hF9C, 12'h800, 64, 64, 2'b11, 2'b11}, "en_back");

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
